secure_apb_arbiter: RTL and testbench

SECURE_APB_ARBITER -- requirements
Module: secure_apb_arbiter

---
 rtl/secure_apb_pkg.sv | 34 +++
 rtl/rr_arb2.sv | 20 ++
 rtl/secure_apb_arbiter.sv | 165 ++++++++++++++++
 tb/tb_secure_apb_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/secure_apb_pkg.sv
// Shared types and constants for the secure APB arbiter slice: FSM encoding,
// target-select codes and the captured-request layout.
package secure_apb_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  localparam int STRB_W = 2;

  localparam logic [1:0] PSEL_NONE = 2'b00;
  localparam logic [1:0] PSEL_RM   = 2'b01;
  localparam logic [1:0] PSEL_ICN  = 2'b10;
  localparam logic [1:0] PSEL_BAD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_ABORT  = 2'd3
  } state_e;

  typedef struct packed {
    logic [1:0]        psel;
    logic              pwrite;
    logic [STRB_W-1:0] pstrb;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
  } apb_req_t;

  // Only a single-region select may reach the secure gate; 11 is aborted locally.
  function automatic logic is_valid_psel(input logic [1:0] psel);
    return (psel == PSEL_RM) || (psel == PSEL_ICN);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant, purely combinational.
// rr = 0 gives master 0 priority on a tie, rr = 1 gives master 1 priority.
module rr_arb2 (
  input  logic [1:0] request,
  input  logic       rr,
  output logic [1:0] grant
);

  always_comb begin
    // NOTE: default assignment first so every path drives grant and no latch is inferred.
    grant = 2'b00;
    case (request)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/secure_apb_arbiter.sv
// Two-master APB arbiter in front of the secure gate: round-robin grant,
// single downstream transfer at a time, ACCESS timeout and local abort of PSEL=11.
module secure_apb_arbiter
  import secure_apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [1:0]        m0_psel,
  input  logic              m0_penable,
  input  logic              m0_pwrite,
  input  logic [STRB_W-1:0] m0_pstrb,
  input  logic [ADDR_W-1:0] m0_paddr,
  input  logic [DATA_W-1:0] m0_pwdata,
  output logic [DATA_W-1:0] m0_prdata,
  output logic              m0_pready,
  output logic              m0_pslverr,

  input  logic [1:0]        m1_psel,
  input  logic              m1_penable,
  input  logic              m1_pwrite,
  input  logic [STRB_W-1:0] m1_pstrb,
  input  logic [ADDR_W-1:0] m1_paddr,
  input  logic [DATA_W-1:0] m1_pwdata,
  output logic [DATA_W-1:0] m1_prdata,
  output logic              m1_pready,
  output logic              m1_pslverr,

  output logic [1:0]        psel_s,
  output logic              penable_s,
  output logic              pwrite_s,
  output logic [STRB_W-1:0] pstrb_s,
  output logic [ADDR_W-1:0] paddr_s,
  output logic [DATA_W-1:0] pwdata_s,
  input  logic [DATA_W-1:0] prdata_s,
  input  logic              pready_s,
  input  logic              pslverr_s_rm,
  input  logic              pslverr_s_icn
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e   state_q, state_d;
  apb_req_t req_q, m0_req, m1_req, sel_req;
  logic     gnt_q;
  logic     rr_q;
  logic [7:0] cnt_q;
  logic [1:0] request, grant;
  logic     done;

  // Master penable carries no information here: the arbiter builds its own phases.
  logic unused_penable;
  assign unused_penable = m0_penable ^ m1_penable;

  assign m0_req = '{psel: m0_psel, pwrite: m0_pwrite, pstrb: m0_pstrb,
                    paddr: m0_paddr, pwdata: m0_pwdata};
  assign m1_req = '{psel: m1_psel, pwrite: m1_pwrite, pstrb: m1_pstrb,
                    paddr: m1_paddr, pwdata: m1_pwdata};

  assign request = {|m1_psel, |m0_psel};

  rr_arb2 u_rr_arb2 (
    .request (request),
    .rr      (rr_q),
    .grant   (grant)
  );

  assign sel_req = grant[1] ? m1_req : m0_req;

  // A transfer ends on pready in ACCESS (even on the timeout cycle) or after ABORT.
  assign done = ((state_q == ST_ACCESS) && pready_s) || (state_q == ST_ABORT);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all state updates see pre-edge values.
    if (reset) begin
      state_q <= ST_IDLE;
      rr_q    <= 1'b0;
      gnt_q   <= 1'b0;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && (|grant)) begin
        gnt_q <= grant[1];
        req_q <= sel_req;
      end
      cnt_q <= (state_q == ST_ACCESS) ? cnt_q + 8'd1 : 8'd0;
      if (done) begin
        rr_q <= ~gnt_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          state_d = is_valid_psel(sel_req.psel) ? ST_SETUP : ST_ABORT;
        end
      end
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (pready_s) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_ABORT;
        end
      end
      ST_ABORT:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    psel_s     = PSEL_NONE;
    penable_s  = 1'b0;
    pwrite_s   = 1'b0;
    pstrb_s    = '0;
    paddr_s    = '0;
    pwdata_s   = '0;
    m0_prdata  = '0;
    m0_pready  = 1'b0;
    m0_pslverr = 1'b0;
    m1_prdata  = '0;
    m1_pready  = 1'b0;
    m1_pslverr = 1'b0;

    if ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) begin
      psel_s    = req_q.psel;
      penable_s = (state_q == ST_ACCESS);
      pwrite_s  = req_q.pwrite;
      pstrb_s   = req_q.pstrb;
      paddr_s   = req_q.paddr;
      pwdata_s  = req_q.pwdata;
    end

    case (state_q)
      ST_ACCESS: begin
        if (!gnt_q) begin
          m0_prdata  = prdata_s;
          m0_pready  = pready_s;
          m0_pslverr = pslverr_s_rm | pslverr_s_icn;
        end else begin
          m1_prdata  = prdata_s;
          m1_pready  = pready_s;
          m1_pslverr = pslverr_s_rm | pslverr_s_icn;
        end
      end
      ST_ABORT: begin
        if (!gnt_q) begin
          m0_pready  = 1'b1;
          m0_pslverr = 1'b1;
        end else begin
          m1_pready  = 1'b1;
          m1_pslverr = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_secure_apb_arbiter.sv
// Self-checking bench for secure_apb_arbiter: directed scenarios plus randomized
// transfers checked against a transaction-level round-robin/timeout model.
module tb_secure_apb_arbiter;
  import secure_apb_pkg::*;

  localparam int TIMEOUT = 4;

  logic clk;
  logic reset;
  logic [1:0] m0_psel, m1_psel;
  logic m0_penable, m0_pwrite, m1_penable, m1_pwrite;
  logic [1:0] m0_pstrb, m1_pstrb;
  logic [19:0] m0_paddr, m1_paddr;
  logic [15:0] m0_pwdata, m1_pwdata;
  logic [15:0] m0_prdata, m1_prdata;
  logic m0_pready, m0_pslverr, m1_pready, m1_pslverr;
  logic [1:0] psel_s;
  logic penable_s, pwrite_s;
  logic [1:0] pstrb_s;
  logic [19:0] paddr_s;
  logic [15:0] pwdata_s;
  logic [15:0] prdata_s;
  logic pready_s, pslverr_s_rm, pslverr_s_icn;

  int n_tests = 0;
  int n_fail  = 0;
  int rr_m    = 0;

  logic [1:0]  sh_psel[2];
  logic        sh_pwrite[2];
  logic [1:0]  sh_pstrb[2];
  logic [19:0] sh_paddr[2];
  logic [15:0] sh_pwdata[2];

  secure_apb_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite),
    .m0_pstrb(m0_pstrb), .m0_paddr(m0_paddr), .m0_pwdata(m0_pwdata),
    .m0_prdata(m0_prdata), .m0_pready(m0_pready), .m0_pslverr(m0_pslverr),
    .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite),
    .m1_pstrb(m1_pstrb), .m1_paddr(m1_paddr), .m1_pwdata(m1_pwdata),
    .m1_prdata(m1_prdata), .m1_pready(m1_pready), .m1_pslverr(m1_pslverr),
    .psel_s(psel_s), .penable_s(penable_s), .pwrite_s(pwrite_s),
    .pstrb_s(pstrb_s), .paddr_s(paddr_s), .pwdata_s(pwdata_s),
    .prdata_s(prdata_s), .pready_s(pready_s),
    .pslverr_s_rm(pslverr_s_rm), .pslverr_s_icn(pslverr_s_icn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] resp(input int i);
    return (i == 0) ? {m0_pready, m0_pslverr, m0_prdata}
                    : {m1_pready, m1_pslverr, m1_prdata};
  endfunction

  function automatic logic [42:0] downstream();
    return {psel_s, penable_s, pwrite_s, pstrb_s, paddr_s, pwdata_s};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_master(input int i, input logic [1:0] p, input logic w,
                            input logic [1:0] s, input logic [19:0] a, input logic [15:0] d);
    sh_psel[i] = p; sh_pwrite[i] = w; sh_pstrb[i] = s; sh_paddr[i] = a; sh_pwdata[i] = d;
    if (i == 0) begin
      m0_psel = p; m0_pwrite = w; m0_pstrb = s; m0_paddr = a; m0_pwdata = d;
      m0_penable = $urandom_range(0, 1) != 0;
    end else begin
      m1_psel = p; m1_pwrite = w; m1_pstrb = s; m1_paddr = a; m1_pwdata = d;
      m1_penable = $urandom_range(0, 1) != 0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_master(0, 2'b00, 1'b0, 2'b00, 20'h0, 16'h0);
    set_master(1, 2'b00, 1'b0, 2'b00, 20'h0, 16'h0);
    pready_s = 1'b0; pslverr_s_rm = 1'b0; pslverr_s_icn = 1'b0; prdata_s = 16'h0;
    step();
    step();
    n_tests++;
    if ({downstream(), resp(0), resp(1)} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", {downstream(), resp(0), resp(1)});
    end
    reset = 1'b0;
    rr_m = 0;
  endtask

  // Serves the master the model says is granted; entered at an IDLE cycle with
  // requests already driven. waits = ACCESS cycles before pready_s.
  task automatic serve(input int who, input int waits, input logic [15:0] rdata,
                       input logic erm, input logic eicn);
    int other = 1 - who;
    int psel_cycles = 0;
    int pulses = 0;
    int exp_cycles;
    logic [1:0] p = sh_psel[who];
    logic w = sh_pwrite[who];
    logic [1:0] s = sh_pstrb[who];
    logic [19:0] a = sh_paddr[who];
    logic [15:0] d = sh_pwdata[who];
    bit valid = (p == PSEL_RM) || (p == PSEL_ICN);
    bit done = 0;
    bit aborted = !valid;
    logic [17:0] rw;

    #1;
    n_tests++;
    if ({psel_s, penable_s, m0_pready, m1_pready} !== 5'b0) begin
      n_fail++;
      $display("FAIL idle_grant_cycle m%0d: got %h expected 0", who,
               {psel_s, penable_s, m0_pready, m1_pready});
    end
    step();
    // Winner withdraws and scrambles its request; the captured copy must persist.
    set_master(who, 2'b00, ~w, ~s, ~a, ~d);

    if (valid) begin
      #1;
      n_tests++;
      if ({downstream(), resp(0), resp(1)} !== {p, 1'b0, w, s, a, d, 36'h0}) begin
        n_fail++;
        $display("FAIL setup_phase m%0d: got %h expected %h", who,
                 {downstream(), resp(0), resp(1)}, {p, 1'b0, w, s, a, d, 36'h0});
      end
      if (psel_s === p) psel_cycles++;
      step();
      for (int i = 0; !done && !aborted; i++) begin
        pready_s      = (i == waits);
        pslverr_s_rm  = (i == waits) && erm;
        pslverr_s_icn = (i == waits) && eicn;
        prdata_s      = rdata;
        #1;
        if (psel_s === p) psel_cycles++;
        rw = resp(who);
        n_tests++;
        if ({downstream(), rw, resp(other)} !==
            {p, 1'b1, w, s, a, d, (i == waits), (i == waits) && (erm || eicn), rdata, 18'h0}) begin
          n_fail++;
          $display("FAIL access_cycle%0d m%0d: got %h expected %h", i, who,
                   {downstream(), rw, resp(other)},
                   {p, 1'b1, w, s, a, d, (i == waits), (i == waits) && (erm || eicn), rdata, 18'h0});
        end
        if (rw[17] === 1'b1) pulses++;
        done    = (i == waits);
        aborted = !done && (i == TIMEOUT - 1);
        step();
        pready_s = 1'b0; pslverr_s_rm = 1'b0; pslverr_s_icn = 1'b0;
        prdata_s = 16'($urandom);
      end
      exp_cycles = 1 + ((waits < TIMEOUT) ? waits + 1 : TIMEOUT);
      n_tests++;
      if (psel_cycles != exp_cycles || pulses != (done ? 1 : 0)) begin
        n_fail++;
        $display("FAIL transfer_shape m%0d: psel cycles %0d pulses %0d expected %0d and %0d",
                 who, psel_cycles, pulses, exp_cycles, done ? 1 : 0);
      end
    end

    if (aborted) begin
      #1;
      n_tests++;
      if ({psel_s, penable_s, resp(who), resp(other)} !== {3'b0, 2'b11, 16'h0, 18'h0}) begin
        n_fail++;
        $display("FAIL abort_cycle m%0d: got %h expected %h", who,
                 {psel_s, penable_s, resp(who), resp(other)}, {3'b0, 2'b11, 16'h0, 18'h0});
      end
      step();
    end
    rr_m = other;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_basic_write();
    set_master(0, PSEL_ICN, 1'b1, 2'b11, 20'h00C1A, 16'hA007);
    serve(0, 2, 16'h1234, 1'b0, 1'b0);
  endtask

  task automatic test_read_error();
    set_master(1, PSEL_RM, 1'b0, 2'b00, 20'h3F000, 16'h0000);
    serve(1, 0, 16'hBEEF, 1'b1, 1'b0);
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int round = 0; round < 2; round++) begin
      set_master(0, PSEL_ICN, 1'b1, 2'b01, 20'h00100 + 20'(round), 16'h5A00);
      set_master(1, PSEL_RM, 1'b0, 2'b10, 20'h00200 + 20'(round), 16'hA500);
      serve(rr_m, 1, 16'h0F0F, 1'b0, 1'b0);
      serve(rr_m, 0, 16'hF0F0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_timeout();
    set_master(0, PSEL_RM, 1'b1, 2'b11, 20'h0ABCD, 16'h7777);
    serve(0, 1000, 16'h4242, 1'b0, 1'b0);
    // pready on the very last allowed ACCESS cycle is a normal completion.
    set_master(0, PSEL_ICN, 1'b0, 2'b01, 20'h0ABCE, 16'h8888);
    serve(0, TIMEOUT - 1, 16'h2424, 1'b0, 1'b0);
  endtask

  task automatic test_bad_psel();
    set_master(1, PSEL_BAD, 1'b1, 2'b11, 20'hFFFFF, 16'hDEAD);
    serve(1, 0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_transfer();
    set_master(0, PSEL_ICN, 1'b1, 2'b11, 20'h12345, 16'h6789);
    step();
    set_master(0, 2'b00, 1'b0, 2'b00, 20'h0, 16'h0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    rr_m = 0;
    #1;
    n_tests++;
    if ({downstream(), resp(0), resp(1)} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_transfer: got %h expected 0", {downstream(), resp(0), resp(1)});
    end
    step();
    set_master(0, PSEL_RM, 1'b0, 2'b10, 20'h00042, 16'h0);
    set_master(1, PSEL_ICN, 1'b1, 2'b01, 20'h00043, 16'h1111);
    serve(rr_m, 0, 16'hC0DE, 1'b0, 1'b0);
    serve(rr_m, 2, 16'hD00D, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      int mask = $urandom_range(1, 3);
      int first;
      for (int m = 0; m < 2; m++) begin
        if (mask[m]) begin
          set_master(m, 2'($urandom_range(1, 3)), 1'($urandom), 2'($urandom),
                     20'($urandom), 16'($urandom));
        end
      end
      first = (mask == 3) ? rr_m : ((mask == 1) ? 0 : 1);
      serve(first, $urandom_range(0, 5), 16'($urandom), 1'($urandom), 1'($urandom));
      if (mask == 3) begin
        serve(rr_m, $urandom_range(0, 5), 16'($urandom), 1'($urandom), 1'($urandom));
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    set_master(0, 2'b00, 1'b0, 2'b00, 20'h0, 16'h0);
    set_master(1, 2'b00, 1'b0, 2'b00, 20'h0, 16'h0);
    pready_s = 1'b0; pslverr_s_rm = 1'b0; pslverr_s_icn = 1'b0; prdata_s = 16'h0;
    test_reset();
    test_basic_write();
    test_read_error();
    test_round_robin();
    test_timeout();
    test_bad_psel();
    test_reset_mid_transfer();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
